// File: rtl/pipe_share_ctrl.sv
// Round-robin shared fixed-latency delay pipeline for two requesters.
// Optional freeze input enabled by defining PIPE_SHARE_STALL_EN.
module pipe_share_ctrl #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    input  logic             flush,
`ifdef PIPE_SHARE_STALL_EN
    input  logic             stall,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             dout_id,
    output logic             busy
);

    logic             hold;
    logic             block;
    logic             last_id;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] id_q, id_d;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];

`ifdef PIPE_SHARE_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // Reset, flush and stall all suppress acceptance so no token is lost.
    assign block = !rst_n || flush || hold;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!block) begin
            if (req0 && req1) begin
                gnt0 = last_id;
                gnt1 = !last_id;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            dat_d[k] = dat_q[k];
        end
        if (flush) begin
            vld_d = '0;
            id_d  = '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                dat_d[k] = '0;
            end
        end else if (!hold) begin
            vld_d[0] = gnt0 | gnt1;
            id_d[0]  = gnt1;
            dat_d[0] = gnt0 ? din0 : (gnt1 ? din1 : '0);
            for (int unsigned k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                id_d[k]  = id_q[k-1];
                dat_d[k] = dat_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            id_q    <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                dat_q[k] <= '0;
            end
            last_id <= 1'b1;
            busy    <= 1'b0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                dat_q[k] <= dat_d[k];
            end
            if (gnt0) begin
                last_id <= 1'b0;
            end else if (gnt1) begin
                last_id <= 1'b1;
            end
            busy <= |vld_d;
        end
    end

    assign dout       = dat_q[DEPTH-1];
    assign dout_valid = vld_q[DEPTH-1];
    assign dout_id    = id_q[DEPTH-1];

endmodule
